// File: rtl/regfile_dump_if.sv
// Register-dump bus: start request, register-file read port and the
// valid/ready word stream with busy/done status.
// master = dump engine side, slave = register file / consumer side.
interface regfile_dump_if;
    logic        start;
    logic [4:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    modport master (
        input  start, rf_rd, out_ready,
        output rf_ra, out_valid, out_addr, out_data, out_last, busy, done
    );

    modport slave (
        output start, rf_rd, out_ready,
        input  rf_ra, out_valid, out_addr, out_data, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: streams registers FIRST_REG..LAST_REG of a register file
// (asynchronous read port) out over a valid/ready word interface.
// Optional feature macro REGDUMP_CHECKSUM_EN: appends one trailing word
// (addr 0, data = XOR of all accepted register words, out_last = 1).
//
// state | meaning
// IDLE  | waiting for start; read address parked at 0
// LOAD  | read register idx, capture value/address into output registers
// SEND  | present captured word until out_valid && out_ready
// CSUM  | present accumulated XOR word (checksum build only)
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input logic              clk,
    input logic              reset,
    regfile_dump_if.master   bus
);

    if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad_range
        $error("regfile_dump: FIRST_REG/LAST_REG must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic [4:0]  rf_ra;
    logic        out_valid;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    // State and captured-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        rf_ra      = '0;
        out_valid  = 1'b0;
        out_addr   = out_addr_q;
        out_data   = out_data_q;
        out_last   = out_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d   = FIRST_IDX;
                    state_d = S_LOAD;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                rf_ra      = idx_q;
                out_data_d = bus.rf_rd;
                out_addr_d = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d = 1'b0;
`else
                out_last_d = (idx_q == LAST_IDX);
`endif
                state_d    = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d = csum_q ^ out_data_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_LOAD;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                out_valid = 1'b1;
                out_addr  = '0;
                out_data  = csum_q;
                out_last  = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rf_ra     = rf_ra;
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_addr;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);

endmodule
